// File: rtl/dds_mod_synth_if.sv
// Sample, configuration and ROM bus of the DDS waveform synthesizer.
// The master side drives stimulus and models the ROMs; the slave side is the synthesizer core.
interface dds_if #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 8,
  parameter int OUT_W   = 8
);
  logic               sample_en;
  logic [2:0]         mode;
  logic               key;
  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [PHASE_W-1:0] cfg_data;
  logic               cfg_commit;
  logic [ADDR_W-1:0]  car_addr;
  logic [OUT_W-1:0]   car_data;
  logic [ADDR_W-1:0]  mod_addr;
  logic [OUT_W-1:0]   mod_data;
  logic [OUT_W-1:0]   wave_out;
  logic               wave_valid;

  modport master (
    output sample_en, mode, key, cfg_we, cfg_sel, cfg_data, cfg_commit,
    output car_data, mod_data,
    input  car_addr, mod_addr, wave_out, wave_valid
  );

  modport slave (
    input  sample_en, mode, key, cfg_we, cfg_sel, cfg_data, cfg_commit,
    input  car_data, mod_data,
    output car_addr, mod_addr, wave_out, wave_valid
  );
endinterface

// File: rtl/dds_mod_synth.sv
// Multi-mode DDS synthesizer: one phase-continuous carrier accumulator plus a modulator
// accumulator, feeding two external 1-cycle ROMs; sine/AM/FM/ASK/FSK/PSK output shaping.
module dds_mod_synth #(
  parameter int PHASE_W  = 16,
  parameter int ADDR_W   = 8,
  parameter int OUT_W    = 8,
  parameter int FM_SHIFT = 2
) (
  input  logic clk,
  input  logic reset,
  dds_if.slave bus
);
  localparam logic [OUT_W-1:0]  MID  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] HALF = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam int                PW   = 2 * OUT_W + 2;

  localparam logic [2:0] MODE_SINE = 3'd0;
  localparam logic [2:0] MODE_AM   = 3'd1;
  localparam logic [2:0] MODE_FM   = 3'd2;
  localparam logic [2:0] MODE_ASK  = 3'd3;
  localparam logic [2:0] MODE_FSK  = 3'd4;
  localparam logic [2:0] MODE_PSK  = 3'd5;

  // FM increment: base tuning word plus the centred, scaled modulator sample.
  function automatic logic [PHASE_W-1:0] fm_inc(input logic [PHASE_W-1:0] f0,
                                                input logic [OUT_W-1:0]   hold);
    logic signed [OUT_W:0]     dev;
    logic signed [PHASE_W-1:0] dev_ext;
    dev     = $signed({1'b0, hold}) - $signed({1'b0, MID});
    dev_ext = PHASE_W'(dev);
    return f0 + (dev_ext <<< FM_SHIFT);
  endfunction

  // AM mix: floor((car - MID) * mod / 2^OUT_W) re-centred; the range never exceeds OUT_W bits.
  function automatic logic [OUT_W-1:0] am_mix(input logic [OUT_W-1:0] car,
                                              input logic [OUT_W-1:0] md);
    logic signed [OUT_W:0] c;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  scaled;
    c      = $signed({1'b0, car}) - $signed({1'b0, MID});
    prod   = PW'(c) * PW'($signed({1'b0, md}));
    scaled = prod >>> OUT_W;
    return MID + OUT_W'(scaled);
  endfunction

  function automatic logic [OUT_W-1:0] shape(input logic [2:0]       m,
                                             input logic             k,
                                             input logic [OUT_W-1:0] car,
                                             input logic [OUT_W-1:0] md);
    case (m)
      MODE_SINE, MODE_FM, MODE_FSK, MODE_PSK: shape = car;
      MODE_AM:  shape = am_mix(car, md);
      MODE_ASK: shape = k ? car : MID;
      default:  shape = MID;
    endcase
  endfunction

  logic [PHASE_W-1:0] sh_f0_q, sh_f0_d, sh_f1_q, sh_f1_d, sh_mod_q, sh_mod_d;
  logic [PHASE_W-1:0] f0_q, f0_d, f1_q, f1_d, fmod_q, fmod_d;
  logic               pending_q, pending_d;
  logic               load;
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W-1:0] car_acc_q, car_acc_d, mod_acc_q, mod_acc_d;
  logic               vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [2:0]         mode_p0_q, mode_p0_d, mode_p1_q, mode_p1_d, mode_p2_q, mode_p2_d;
  logic               key_p0_q, key_p0_d, key_p1_q, key_p1_d, key_p2_q, key_p2_d;
  logic [ADDR_W-1:0]  car_addr_q, car_addr_d, mod_addr_q, mod_addr_d;
  logic [OUT_W-1:0]   wave_out_q, wave_out_d, mod_hold_q, mod_hold_d;
  logic               wave_valid_q, wave_valid_d;

  always_comb begin
    // Configuration: a load takes the pre-write shadow, so a coincident write stays unloaded.
    load      = bus.sample_en && (pending_q || bus.cfg_commit);
    sh_f0_d   = sh_f0_q;
    sh_f1_d   = sh_f1_q;
    sh_mod_d  = sh_mod_q;
    if (bus.cfg_we) begin
      case (bus.cfg_sel)
        2'd0:    sh_f0_d  = bus.cfg_data;
        2'd1:    sh_f1_d  = bus.cfg_data;
        2'd2:    sh_mod_d = bus.cfg_data;
        default: ;
      endcase
    end
    f0_d      = load ? sh_f0_q  : f0_q;
    f1_d      = load ? sh_f1_q  : f1_q;
    fmod_d    = load ? sh_mod_q : fmod_q;
    pending_d = load ? 1'b0 : (pending_q || bus.cfg_commit);

    // Stage E0: accumulators advance with the freshly loaded tuning words
    case (bus.mode)
      MODE_FSK: inc = bus.key ? f1_d : f0_d;
      MODE_FM:  inc = fm_inc(f0_d, mod_hold_q);
      default:  inc = f0_d;
    endcase
    car_acc_d = car_acc_q;
    mod_acc_d = mod_acc_q;
    if (bus.sample_en) begin
      car_acc_d = car_acc_q + inc;
      mod_acc_d = mod_acc_q + fmod_d;
    end
    vld_p0_d  = bus.sample_en;
    mode_p0_d = bus.sample_en ? bus.mode : mode_p0_q;
    key_p0_d  = bus.sample_en ? bus.key  : key_p0_q;

    // Stage E1: ROM addresses from accumulator MSBs, PSK flips the carrier by half a cycle
    car_addr_d = car_addr_q;
    mod_addr_d = mod_addr_q;
    if (vld_p0_q) begin
      car_addr_d = car_acc_q[PHASE_W-1 -: ADDR_W]
                 + (((mode_p0_q == MODE_PSK) && key_p0_q) ? HALF : '0);
      mod_addr_d = mod_acc_q[PHASE_W-1 -: ADDR_W];
    end
    vld_p1_d  = vld_p0_q;
    mode_p1_d = mode_p0_q;
    key_p1_d  = key_p0_q;

    // Stage E2: ROMs register the addresses
    vld_p2_d  = vld_p1_q;
    mode_p2_d = mode_p1_q;
    key_p2_d  = key_p1_q;

    // Stage E3: output shaping and modulator capture for FM
    wave_out_d   = wave_out_q;
    mod_hold_d   = mod_hold_q;
    if (vld_p2_q) begin
      wave_out_d = shape(mode_p2_q, key_p2_q, bus.car_data, bus.mod_data);
      mod_hold_d = bus.mod_data;
    end
    wave_valid_d = vld_p2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_f0_q      <= '0;
      sh_f1_q      <= '0;
      sh_mod_q     <= '0;
      f0_q         <= '0;
      f1_q         <= '0;
      fmod_q       <= '0;
      pending_q    <= 1'b0;
      car_acc_q    <= '0;
      mod_acc_q    <= '0;
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      car_addr_q   <= '0;
      mod_addr_q   <= '0;
      wave_out_q   <= MID;
      wave_valid_q <= 1'b0;
      mod_hold_q   <= MID;
    end else begin
      sh_f0_q      <= sh_f0_d;
      sh_f1_q      <= sh_f1_d;
      sh_mod_q     <= sh_mod_d;
      f0_q         <= f0_d;
      f1_q         <= f1_d;
      fmod_q       <= fmod_d;
      pending_q    <= pending_d;
      car_acc_q    <= car_acc_d;
      mod_acc_q    <= mod_acc_d;
      vld_p0_q     <= vld_p0_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      car_addr_q   <= car_addr_d;
      mod_addr_q   <= mod_addr_d;
      wave_out_q   <= wave_out_d;
      wave_valid_q <= wave_valid_d;
      mod_hold_q   <= mod_hold_d;
    end
  end

  // Mode/key tags only matter alongside a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    mode_p0_q <= mode_p0_d;
    mode_p1_q <= mode_p1_d;
    mode_p2_q <= mode_p2_d;
    key_p0_q  <= key_p0_d;
    key_p1_q  <= key_p1_d;
    key_p2_q  <= key_p2_d;
  end

  assign bus.car_addr   = car_addr_q;
  assign bus.mod_addr   = mod_addr_q;
  assign bus.wave_out   = wave_out_q;
  assign bus.wave_valid = wave_valid_q;
endmodule

// File: tb/tb_dds_mod_synth.sv
// Directed bench for dds_mod_synth: ROM models, scoreboard queues for addresses and samples,
// and a per-cycle monitor comparing against the expected 3-clock latency.
module tb_dds_mod_synth;
  localparam int PW = 16;
  localparam int AW = 8;
  localparam int OW = 8;
  localparam logic [2:0] M_SINE = 3'd0, M_AM = 3'd1, M_FM = 3'd2, M_ASK = 3'd3,
                         M_FSK = 3'd4, M_PSK = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dds_if #(.PHASE_W(PW), .ADDR_W(AW), .OUT_W(OW)) bus();

  dds_mod_synth #(.PHASE_W(PW), .ADDR_W(AW), .OUT_W(OW), .FM_SHIFT(2)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]    exp_addr_q[$];
  logic [7:0]    exp_out_q[$];
  logic [PW-1:0] ph = '0;
  logic          car_const_en = 1'b0;
  logic [7:0]    car_const = 8'h00;
  logic [7:0]    mod_const = 8'h80;
  logic [4:1]    lh = '0;
  logic [7:0]    mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rom_car(input logic [7:0] a);
    logic [7:0] v;
    v = a * 8'd7 + 8'h13;
    return car_const_en ? car_const : v;
  endfunction

  function automatic logic [7:0] ref_out(input logic [2:0] m, input logic k,
                                         input logic [7:0] car, input logic [7:0] md);
    int c, p, q;
    case (m)
      M_SINE, M_FM, M_FSK, M_PSK: return car;
      M_AM: begin
        c = int'(car) - 128;
        p = c * int'(md);
        q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        return 8'(128 + q);
      end
      M_ASK:   return k ? car : 8'h80;
      default: return 8'h80;
    endcase
  endfunction

  always @(posedge clk) begin
    bus.car_data <= rom_car(bus.car_addr);
    bus.mod_data <= mod_const;
  end

  always @(posedge clk) begin
    if (reset) lh <= '0;
    else       lh <= {lh[3:1], bus.sample_en};
  end

  always @(negedge clk) begin
    chk("wave_valid", 32'(bus.wave_valid), 32'(lh[4]));
    if (lh[2]) begin
      chk("addr_q_nonempty", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) begin
        mon_e = exp_addr_q.pop_front();
        chk("car_addr", 32'(bus.car_addr), 32'(mon_e));
        chk("mod_addr", 32'(bus.mod_addr), 32'd0);
      end
    end
    if (lh[4]) begin
      chk("out_q_nonempty", 32'(exp_out_q.size() != 0), 32'd1);
      if (exp_out_q.size() != 0) begin
        mon_e = exp_out_q.pop_front();
        chk("wave_out", 32'(bus.wave_out), 32'(mon_e));
      end
    end
  end

  task automatic launch(input logic [2:0] m, input logic k, input logic [PW-1:0] inc);
    logic [7:0] a;
    bus.sample_en = 1'b1;
    bus.mode      = m;
    bus.key       = k;
    ph = ph + inc;
    a  = ph[PW-1 -: 8];
    if (m == M_PSK && k) a = a + 8'h80;
    exp_addr_q.push_back(a);
    exp_out_q.push_back(ref_out(m, k, rom_car(a), mod_const));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.sample_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [PW-1:0] d);
    bus.sample_en = 1'b0;
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_data  = d;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic commit_only();
    bus.sample_en  = 1'b0;
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    bus.cfg_commit = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_wave_out"}, 32'(bus.wave_out), 32'h80);
    chk({tag, "_wave_valid"}, 32'(bus.wave_valid), 32'd0);
    chk({tag, "_car_addr"}, 32'(bus.car_addr), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.sample_en  = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_commit = 1'b0;
    @(negedge clk);
    exp_addr_q.delete();
    exp_out_q.delete();
    ph = '0;
    chk_rst("rst_a");
    bus.sample_en = 1'b0;
    @(negedge clk);
    chk_rst("rst_b");
    reset = 1'b0;
    @(negedge clk);
    chk_rst("rst_rel");
  endtask

  initial begin
    bus.sample_en = 1'b0; bus.mode = M_SINE; bus.key = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_data = '0; bus.cfg_commit = 1'b0;

    // Reset with sample_en toggling.
    do_reset();

    // Sine stepping with wrap of the carrier address.
    cfg_write(2'd0, 16'h0100);
    commit_only();
    for (int i = 0; i < 260; i++) launch(M_SINE, 1'b0, 16'h0100);
    idle(5);

    // FSK: phase-continuous switch at address 0x10, then ASK and idle modes.
    cfg_write(2'd1, 16'h0400);
    commit_only();
    while (ph[PW-1 -: 8] != 8'h10) launch(M_FSK, 1'b0, 16'h0100);
    for (int i = 0; i < 4; i++) launch(M_FSK, 1'b1, 16'h0400);
    launch(M_ASK, 1'b0, 16'h0100);
    launch(M_ASK, 1'b1, 16'h0100);
    launch(3'd6, 1'b1, 16'h0100);
    launch(3'd7, 1'b0, 16'h0100);
    idle(5);

    // PSK with zero tuning word.
    do_reset();
    launch(M_PSK, 1'b0, 16'h0000);
    launch(M_PSK, 1'b0, 16'h0000);
    launch(M_PSK, 1'b1, 16'h0000);
    launch(M_PSK, 1'b1, 16'h0000);
    launch(M_PSK, 1'b0, 16'h0000);
    idle(5);

    // AM with constant ROMs, then FM with the held modulator at 0x00.
    do_reset();
    cfg_write(2'd0, 16'h0100);
    commit_only();
    car_const_en = 1'b1;
    car_const = 8'hFF; mod_const = 8'h80; launch(M_AM, 1'b0, 16'h0100); idle(5);
    car_const = 8'h00; mod_const = 8'hFF; launch(M_AM, 1'b0, 16'h0100); idle(5);
    car_const = 8'h40; mod_const = 8'hC0; launch(M_AM, 1'b0, 16'h0100); idle(5);
    car_const = 8'h5A; mod_const = 8'h00; launch(M_AM, 1'b0, 16'h0100); idle(5);
    for (int i = 0; i < 3; i++) launch(M_FM, 1'b0, 16'hFF00);
    idle(5);
    car_const_en = 1'b0;
    mod_const    = 8'h80;

    // Config race: write coinciding with a load edge, then a later commit; mid-stream reset.
    do_reset();
    cfg_write(2'd0, 16'h0100);
    commit_only();
    launch(M_SINE, 1'b0, 16'h0100);
    bus.cfg_we = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_data = 16'h0200; bus.cfg_commit = 1'b1;
    launch(M_SINE, 1'b0, 16'h0100);
    bus.cfg_we = 1'b0; bus.cfg_commit = 1'b0;
    for (int i = 0; i < 3; i++) launch(M_SINE, 1'b0, 16'h0100);
    commit_only();
    for (int i = 0; i < 6; i++) launch(M_SINE, 1'b0, 16'h0200);
    do_reset();
    idle(6);

    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("out_q_drained", 32'(exp_out_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dds_mod_synth.md
# dds_mod_synth

Parametrised multi-mode DDS waveform synthesizer. Next generation of the board's signal generator core. It replaces divided clocks with a single clock plus a sample strobe, and replaces dual accumulators with one phase-continuous carrier accumulator. It produces sine, AM, FM, ASK, FSK and PSK samples for the DAC output path. Sine data comes from two external synchronous look-up ROMs (carrier, modulator).

## Interface
Parameters:
- PHASE_W, 16: phase accumulator and tuning word width.
- ADDR_W, 8: ROM address width; taken from the accumulator MSBs; ADDR_W ≤ PHASE_W.
- OUT_W, 8: sample width. Offset binary; midscale MID = 2^(OUT_W-1).
- FM_SHIFT, 2: left shift applied to the centred modulator sample to form the FM deviation.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- sample_en  in  1  advance one sample. May be high every cycle.
- mode  in  3  waveform select: 000 sine, 001 AM, 010 FM, 011 ASK, 100 FSK, 101 PSK, others idle.
- key  in  1  keying bit for ASK/FSK/PSK.
- cfg_we  in  1  shadow register write strobe.
- cfg_sel  in  2  shadow register select: 0 ftw_f0, 1 ftw_f1, 2 ftw_mod.
- cfg_data  in  PHASE_W  write data.
- cfg_commit  in  1  request shadow→active transfer.
- car_addr  out  ADDR_W  carrier ROM address (registered).
- car_data  in  OUT_W  carrier ROM data. 1-cycle synchronous ROM latency.
- mod_addr  out  ADDR_W  modulator ROM address (registered).
- mod_data  in  OUT_W  modulator ROM data. 1-cycle latency.
- wave_out  out  OUT_W  output sample.
- wave_valid  out  1  one-cycle pulse per output sample.

## Operation
- Configuration:
  - cfg_we writes shadow[cfg_sel].
  - cfg_commit sets a pending flag.
  - Active registers load from shadow at the first sample_en edge where pending or cfg_commit is high. The flag then clears.
  - If cfg_we and the load edge coincide, the load takes the pre-write shadow value. The new write stays in shadow and is not pending.
  - At a load edge, the accumulators increment using the newly loaded values.
- Mod accumulator: on every sample_en, mod_acc += ftw_mod, in all modes.
- Carrier accumulator: on sample_en, car_acc += inc, all arithmetic mod 2^PHASE_W. The increment inc depends on mode:
  - FSK: key ? ftw_f1 : ftw_f0. Phase-continuous; no accumulator reset on key change.
  - FM: ftw_f0 + (sext(mod_hold − MID) << FM_SHIFT). mod_hold is the last modulator ROM sample captured in stage 3; its reset value is MID.
  - All other modes: ftw_f0.
- Mode and key are sampled at the sample_en edge and carried down the pipeline with their sample.
- Mode changes never reset the accumulators.
- Carrier address: car_acc[PHASE_W-1 -: ADDR_W], plus 2^(ADDR_W-1) (mod 2^ADDR_W) when mode is PSK and key is 1.
- Modulator address: mod_acc[PHASE_W-1 -: ADDR_W].
- Output function (c = car_data − MID, signed; m = mod_data, unsigned):
  - sine, FM, FSK, PSK: car_data.
  - AM: MID + ((c·m) >>> OUT_W), arithmetic shift with floor. The result always fits OUT_W bits; no saturation is needed.
  - ASK: key ? car_data : MID.
  - idle modes: MID.

## Timing
- Call the sample_en edge E0.
  - E0: accumulators update.
  - E1: car_addr and mod_addr register.
  - E2: ROMs register the addresses.
  - E3: wave_out registers and wave_valid goes high for one cycle.
- Latency: 3 clocks from sample_en to wave_valid. Fully pipelined, so back-to-back sample_en gives back-to-back wave_valid.
- With sample_en low, the accumulators and addresses hold and wave_valid stays 0.
- Reset values: all accumulators, shadow and active registers are 0, the pending flag is clear, car_addr and mod_addr are 0, wave_out is MID, wave_valid is 0, mod_hold is MID.
- Reset asserted mid-stream discards every in-flight sample: no wave_valid for samples launched before reset.
- Wrap-around: the accumulators overflow silently. car_addr wraps from 2^ADDR_W−1 to 0 without a glitch.

## Test plan
1. Reset: hold reset high 2 cycles while toggling sample_en. Required: wave_out=0x80, wave_valid=0, car_addr=0x00 throughout and after release.
2. Sine: write ftw_f0=0x0100, commit, then sample_en every cycle. Required: car_addr steps 0x01,0x02,…; the first wave_valid comes 3 cycles after the first sample_en; car_addr wraps 0xFF→0x00 after 256 samples.
3. FSK: ftw_f0=0x0100, ftw_f1=0x0400; raise key when car_addr=0x10. Required: next car_addr=0x14 (no phase jump), then +4 per sample.
4. PSK: ftw_f0=0; key 0→1. Required: car_addr 0x00→0x80; wave_out equals the ROM value at 0x80, 3 cycles after the key is sampled.
5. AM with a constant-data ROM model. Required:
   - car_data=0xFF, mod_data=0x80 → wave_out=0xBF.
   - car_data=0x00, mod_data=0xFF → wave_out=0x00.
   - mod_data=0x00 → wave_out=0x80.
6. Config race: cfg_we of ftw_f0=0x0200 in the same cycle as cfg_commit+sample_en, with old shadow 0x0100. Required: the increment uses 0x0100 until a later commit, which then gives steps of 0x02. Also assert reset during streaming. Required: wave_valid drops the next cycle and no stale samples emerge.
